// File: rtl/psg_mixer.sv
//==============================================================================
// Module   : psg_mixer
// Purpose  : Stereo mixer for the four PSG channels (square1, square2, wave,
//            noise). Once per sample period it snapshots the channels and the
//            sound-control registers, accumulates the enabled channels per side
//            over four cycles, applies side volume, PSG volume and master
//            enable, saturates, and offers the result on a valid/ready port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports:
//   system_clock        in   clock, rising edge
//   reset               in   asynchronous reset, active low
//   ch1..ch4_wave       in   24-bit signed channel outputs
//   SOUNDCNT_L          in   [2:0] R vol, [6:4] L vol, [11:8] R en, [15:12] L en
//   SOUNDCNT_H          in   [1:0] PSG volume (0=25%,1=50%,2=100%,3=25%)
//   SOUNDCNT_X          in   [7] master enable
//   left/right_sample   out  mixed signed samples, OUT_WIDTH bits
//   sample_valid        out  output buffer holds an unconsumed sample
//   sample_ready        in   consumer accepts when valid && ready
//   overrun_count       out  dropped-sample count, saturates at 255
//   busy                out  mixer is working on a sample
//==============================================================================
`default_nettype none

module psg_mixer #(
  parameter int SAMPLE_DIV = 512,
  parameter int OUT_WIDTH  = 24
) (
  input  logic                 system_clock,
  input  logic                 reset,
  input  logic [23:0]          ch1_wave,
  input  logic [23:0]          ch2_wave,
  input  logic [23:0]          ch3_wave,
  input  logic [23:0]          ch4_wave,
  input  logic [15:0]          SOUNDCNT_L,
  input  logic [15:0]          SOUNDCNT_H,
  input  logic [7:0]           SOUNDCNT_X,
  output logic [OUT_WIDTH-1:0] left_sample,
  output logic [OUT_WIDTH-1:0] right_sample,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic [7:0]           overrun_count,
  output logic                 busy
);

  localparam int c_CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_TICK_LAST = c_CNT_W'(SAMPLE_DIV - 1);

  // Saturation bounds expressed in the 30-bit scaling domain
  localparam logic signed [29:0] c_SAT_MAX = 30'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [29:0] c_SAT_MIN = 30'(-(64'sd1 <<< (OUT_WIDTH - 1)));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC0  = 3'd1,
    S_ACC1  = 3'd2,
    S_ACC2  = 3'd3,
    S_ACC3  = 3'd4,
    S_SCALE = 3'd5
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_tick_cnt;
  logic                w_tick;

  // Snapshot of everything that affects the sample in flight
  logic [23:0]         r_snap_ch1, r_snap_ch2, r_snap_ch3, r_snap_ch4;
  logic [2:0]          r_snap_rvol, r_snap_lvol;
  logic [3:0]          r_snap_ren, r_snap_len;
  logic [1:0]          r_snap_psg;
  logic                r_snap_master;

  logic signed [26:0]  r_acc_l, r_acc_r;

  logic [23:0]         w_sel_ch;
  logic                w_en_l, w_en_r;
  logic signed [26:0]  w_sel_ext;
  logic                w_accept;
  logic [OUT_WIDTH-1:0] w_left_res, w_right_res;

  // Control bits this block does not use
  logic w_unused;
  assign w_unused = ^{SOUNDCNT_H[15:2], SOUNDCNT_X[6:0], SOUNDCNT_L[7], SOUNDCNT_L[3]};

  assign w_tick   = (r_tick_cnt == c_TICK_LAST);
  assign w_accept = sample_valid && sample_ready;

  //--------------------------------------------------------------------------
  // Free-running sample-period counter and input snapshot
  //--------------------------------------------------------------------------
  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      r_tick_cnt    <= '0;
      r_snap_ch1    <= '0;
      r_snap_ch2    <= '0;
      r_snap_ch3    <= '0;
      r_snap_ch4    <= '0;
      r_snap_rvol   <= '0;
      r_snap_lvol   <= '0;
      r_snap_ren    <= '0;
      r_snap_len    <= '0;
      r_snap_psg    <= '0;
      r_snap_master <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + c_CNT_W'(1);
      // A tick always lands in IDLE because the period is at least 8 cycles,
      // so overwriting the snapshot here never disturbs a mix in progress.
      if (w_tick) begin
        r_snap_ch1    <= ch1_wave;
        r_snap_ch2    <= ch2_wave;
        r_snap_ch3    <= ch3_wave;
        r_snap_ch4    <= ch4_wave;
        r_snap_rvol   <= SOUNDCNT_L[2:0];
        r_snap_lvol   <= SOUNDCNT_L[6:4];
        r_snap_ren    <= SOUNDCNT_L[11:8];
        r_snap_len    <= SOUNDCNT_L[15:12];
        r_snap_psg    <= SOUNDCNT_H[1:0];
        r_snap_master <= SOUNDCNT_X[7];
      end
    end
  end

  //--------------------------------------------------------------------------
  // Channel select for the accumulate states
  //--------------------------------------------------------------------------
  always_comb begin
    w_sel_ch = r_snap_ch1;
    w_en_l   = 1'b0;
    w_en_r   = 1'b0;
    case (r_state)
      S_ACC0: begin w_sel_ch = r_snap_ch1; w_en_l = r_snap_len[0]; w_en_r = r_snap_ren[0]; end
      S_ACC1: begin w_sel_ch = r_snap_ch2; w_en_l = r_snap_len[1]; w_en_r = r_snap_ren[1]; end
      S_ACC2: begin w_sel_ch = r_snap_ch3; w_en_l = r_snap_len[2]; w_en_r = r_snap_ren[2]; end
      S_ACC3: begin w_sel_ch = r_snap_ch4; w_en_l = r_snap_len[3]; w_en_r = r_snap_ren[3]; end
      default: ;
    endcase
  end

  assign w_sel_ext = {{3{w_sel_ch[23]}}, w_sel_ch};

  //--------------------------------------------------------------------------
  // Volume scaling and saturation for one side
  //--------------------------------------------------------------------------
  function automatic logic [OUT_WIDTH-1:0] f_scale(
    input logic signed [26:0] acc,
    input logic        [2:0]  vol,
    input logic        [1:0]  psg,
    input logic               master
  );
    logic signed [29:0] m;
    logic        [3:0]  vol1;
    vol1 = {1'b0, vol} + 4'd1;
    m    = {{3{acc[26]}}, acc};
    // 4 channels x 2^23 x 8 stays below 2^29, so 30 bits cannot overflow
    m    = m * $signed({26'd0, vol1});
    m    = m >>> 3;
    case (psg)
      2'd2:    m = m;
      2'd1:    m = m >>> 1;
      default: m = m >>> 2;
    endcase
    if (m > c_SAT_MAX)      m = c_SAT_MAX;
    else if (m < c_SAT_MIN) m = c_SAT_MIN;
    if (!master) m = '0;
    return m[OUT_WIDTH-1:0];
  endfunction

  assign w_left_res  = f_scale(r_acc_l, r_snap_lvol, r_snap_psg, r_snap_master);
  assign w_right_res = f_scale(r_acc_r, r_snap_rvol, r_snap_psg, r_snap_master);

  //--------------------------------------------------------------------------
  // Mixing FSM with registered outputs and output buffer
  //--------------------------------------------------------------------------
  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_acc_l       <= '0;
      r_acc_r       <= '0;
      busy          <= 1'b0;
      left_sample   <= '0;
      right_sample  <= '0;
      sample_valid  <= 1'b0;
      overrun_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_state <= S_ACC0;
            r_acc_l <= '0;
            r_acc_r <= '0;
            busy    <= 1'b1;
          end
        end
        S_ACC0, S_ACC1, S_ACC2, S_ACC3: begin
          if (w_en_l) r_acc_l <= r_acc_l + w_sel_ext;
          if (w_en_r) r_acc_r <= r_acc_r + w_sel_ext;
          case (r_state)
            S_ACC0:  r_state <= S_ACC1;
            S_ACC1:  r_state <= S_ACC2;
            S_ACC2:  r_state <= S_ACC3;
            default: r_state <= S_SCALE;
          endcase
        end
        S_SCALE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase

      // Buffer: a fresh result may replace a sample being consumed this
      // cycle; otherwise the held sample wins and the new one is dropped.
      if (r_state == S_SCALE) begin
        if (!sample_valid || w_accept) begin
          left_sample  <= w_left_res;
          right_sample <= w_right_res;
          sample_valid <= 1'b1;
        end else if (overrun_count != 8'hFF) begin
          overrun_count <= overrun_count + 8'd1;
        end
      end else if (w_accept) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_psg_mixer.sv
//==============================================================================
// Module   : tb_psg_mixer
// Purpose  : Directed self-checking bench for psg_mixer with hand-computed
//            expected samples, latency, overrun and reset behaviour.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_psg_mixer;

  localparam int N  = 16;
  localparam int OW = 24;

  logic          system_clock = 1'b0;
  logic          reset;
  logic [23:0]   ch1_wave, ch2_wave, ch3_wave, ch4_wave;
  logic [15:0]   SOUNDCNT_L, SOUNDCNT_H;
  logic [7:0]    SOUNDCNT_X;
  logic [OW-1:0] left_sample, right_sample;
  logic          sample_valid;
  logic          sample_ready;
  logic [7:0]    overrun_count;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  psg_mixer #(.SAMPLE_DIV(N), .OUT_WIDTH(OW)) dut (
    .system_clock (system_clock),
    .reset        (reset),
    .ch1_wave     (ch1_wave),
    .ch2_wave     (ch2_wave),
    .ch3_wave     (ch3_wave),
    .ch4_wave     (ch4_wave),
    .SOUNDCNT_L   (SOUNDCNT_L),
    .SOUNDCNT_H   (SOUNDCNT_H),
    .SOUNDCNT_X   (SOUNDCNT_X),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun_count(overrun_count),
    .busy         (busy)
  );

  always #5 system_clock = ~system_clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [23:0] c1, input logic [23:0] c2, input logic [23:0] c3,
                        input logic [23:0] c4, input logic [15:0] l, input logic [15:0] h,
                        input logic [7:0] x);
    ch1_wave = c1; ch2_wave = c2; ch3_wave = c3; ch4_wave = c4;
    SOUNDCNT_L = l; SOUNDCNT_H = h; SOUNDCNT_X = x;
  endtask

  // Counts falling edges until sample_valid is seen, bounded
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    for (int i = 0; i < 4 * N; i++) begin
      @(negedge system_clock);
      n++;
      if (sample_valid === 1'b1) break;
    end
    check_val({tag, "_seen"}, {31'd0, sample_valid}, 32'd1);
  endtask

  // Entered one cycle after a valid pulse; next tick is 9 cycles away, so the
  // new inputs are captured and the sample appears N-1 edges later.
  task automatic do_sample(input string tag, input logic [23:0] c1, input logic [23:0] c2,
                           input logic [23:0] c3, input logic [23:0] c4,
                           input logic [15:0] l, input logic [15:0] h, input logic [7:0] x,
                           input logic [23:0] el, input logic [23:0] er);
    int n;
    set_in(c1, c2, c3, c4, l, h, x);
    wait_valid(tag, n);
    check_val({tag, "_period"}, n, N - 1);
    check_val({tag, "_left"},  {8'd0, left_sample},  {8'd0, el});
    check_val({tag, "_right"}, {8'd0, right_sample}, {8'd0, er});
    @(negedge system_clock);
    check_val({tag, "_pulse"}, {31'd0, sample_valid}, 32'd0);
  endtask

  initial begin
    int n;
    reset        = 1'b0;
    sample_ready = 1'b1;
    set_in(24'h010000, 24'h0, 24'h0, 24'h0, 16'h1077, 16'h0002, 8'h80);
    repeat (3) @(negedge system_clock);

    check_val("rst_left",  {8'd0, left_sample},  32'd0);
    check_val("rst_right", {8'd0, right_sample}, 32'd0);
    check_val("rst_valid", {31'd0, sample_valid}, 32'd0);
    check_val("rst_ovr",   {24'd0, overrun_count}, 32'd0);
    check_val("rst_busy",  {31'd0, busy}, 32'd0);

    // Release mid-cycle 0: tick is cycle N-1, valid appears in cycle N+5
    reset = 1'b1;
    wait_valid("first", n);
    check_val("first_latency", n, N + 5);
    check_val("first_left",  {8'd0, left_sample},  32'h010000);
    check_val("first_right", {8'd0, right_sample}, 32'h000000);
    check_val("first_busy",  {31'd0, busy}, 32'd0);
    @(negedge system_clock);
    check_val("first_pulse", {31'd0, sample_valid}, 32'd0);

    // Volume: (vol+1)/8, then PSG shift
    do_sample("lvol3", 24'h010000, 0, 0, 0, 16'h1037, 16'h0002, 8'h80, 24'h008000, 24'h0);
    do_sample("psg1",  24'h010000, 0, 0, 0, 16'h1077, 16'h0001, 8'h80, 24'h008000, 24'h0);
    do_sample("psg3",  24'h010000, 0, 0, 0, 16'h1077, 16'h0003, 8'h80, 24'h004000, 24'h0);

    // Saturation both directions
    do_sample("sat_pos", 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF,
              16'hFF77, 16'h0002, 8'h80, 24'h7FFFFF, 24'h7FFFFF);
    do_sample("sat_neg", 24'h800000, 24'h800000, 24'h800000, 24'h800000,
              16'hFF77, 16'h0002, 8'h80, 24'h800000, 24'h800000);

    // Negative value with floor: -1 * 8 >>> 3 = -1, >>> 2 = -1
    do_sample("neg_floor", 24'hFFFFFF, 0, 0, 0, 16'h0177, 16'h0000, 8'h80, 24'h0, 24'hFFFFFF);

    // Snapshot isolation: tick 9 edges from here, change inputs at T+2
    set_in(24'h010000, 0, 0, 0, 16'h1077, 16'h0002, 8'h80);
    repeat (11) @(negedge system_clock);
    set_in(24'h020000, 0, 0, 0, 16'h0177, 16'h0002, 8'h80);
    wait_valid("snap", n);
    check_val("snap_left",  {8'd0, left_sample},  32'h010000);
    check_val("snap_right", {8'd0, right_sample}, 32'h000000);
    @(negedge system_clock);
    do_sample("snap_next", 24'h020000, 0, 0, 0, 16'h0177, 16'h0002, 8'h80, 24'h0, 24'h020000);

    // Master disable still produces valid pulses of zero
    do_sample("master_off", 24'h100000, 24'h100000, 24'h100000, 24'h100000,
              16'hFF77, 16'h0002, 8'h00, 24'h0, 24'h0);

    // Overrun: hold first sample, two later samples dropped
    sample_ready = 1'b0;
    set_in(24'h030000, 0, 0, 0, 16'h1077, 16'h0002, 8'h80);
    wait_valid("ovr_first", n);
    check_val("ovr_first_left", {8'd0, left_sample}, 32'h030000);
    set_in(24'h050000, 0, 0, 0, 16'h1077, 16'h0002, 8'h80);
    repeat (34) @(negedge system_clock);
    check_val("ovr_valid", {31'd0, sample_valid}, 32'd1);
    check_val("ovr_hold",  {8'd0, left_sample}, 32'h030000);
    check_val("ovr_count", {24'd0, overrun_count}, 32'd2);
    sample_ready = 1'b1;
    @(negedge system_clock);
    check_val("ovr_xfer", {31'd0, sample_valid}, 32'd0);
    wait_valid("ovr_next", n);
    check_val("ovr_next_left", {8'd0, left_sample}, 32'h050000);
    check_val("ovr_count_kept", {24'd0, overrun_count}, 32'd2);

    // Reset during ACC2
    n = 0;
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge system_clock);
      if (busy === 1'b1) break;
    end
    check_val("mid_busy_seen", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge system_clock);
    #2 reset = 1'b0;
    #1;
    check_val("mid_left",  {8'd0, left_sample},  32'd0);
    check_val("mid_right", {8'd0, right_sample}, 32'd0);
    check_val("mid_valid", {31'd0, sample_valid}, 32'd0);
    check_val("mid_ovr",   {24'd0, overrun_count}, 32'd0);
    check_val("mid_busy",  {31'd0, busy}, 32'd0);
    @(negedge system_clock);
    reset = 1'b1;
    wait_valid("post_rst", n);
    check_val("post_rst_latency", n, N + 5);
    check_val("post_rst_left", {8'd0, left_sample}, 32'h050000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
